// File: rtl/div_pipe_hs.sv
// rtl/div_pipe_hs.sv - iterative restoring divider with valid/ready handshake
// Signed/unsigned per transaction, fixed-point FBITS, STEPS quotient bits per clock.
module div_pipe_hs #(
  parameter int WIDTH = 8,
  parameter int FBITS = 0,
  parameter int STEPS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sgn,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dbz,
  output logic             ovf,
  output logic             busy
);

  localparam int ITER = WIDTH + FBITS;
  localparam int NCYC = ITER / STEPS;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CW-1:0]   LAST = CW'(NCYC - 1);
  localparam logic [ITER-1:0] HALF = ITER'(1) << (WIDTH - 1);

  if (!(STEPS == 1 || STEPS == 2 || STEPS == 4) || (ITER % STEPS) != 0 ||
      WIDTH < 2 || FBITS < 0 || FBITS > WIDTH - 1) begin : g_bad_params
    $error("div_pipe_hs: illegal WIDTH/FBITS/STEPS combination");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic             sgn_q, xneg_q, yneg_q;
  logic [WIDTH-1:0] ymag_q;
  logic [WIDTH:0]   acc_q;
  logic [ITER-1:0]  qsh_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quo_res_q, rem_res_q;
  logic             dbz_q, ovf_q;

  logic             accept, last_step, y_zero;
  logic             xneg_in, yneg_in;
  logic [WIDTH-1:0] xmag_in, ymag_in;
  logic [WIDTH:0]   acc_n, acc_sh;
  logic [ITER-1:0]  qsh_n;
  logic [WIDTH-1:0] quo_d, rem_d;
  logic             ovf_d;

  assign y_zero    = (y == '0);
  assign accept    = in_valid & in_ready;
  assign last_step = (cnt_q == LAST);
  assign xneg_in   = sgn & x[WIDTH-1];
  assign yneg_in   = sgn & y[WIDTH-1];
  assign xmag_in   = xneg_in ? -x : x;
  assign ymag_in   = yneg_in ? -y : y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = y_zero ? DONE : CALC;
      CALC: if (last_step) state_d = DONE;
      DONE: begin
        if (out_ready) begin
          if (accept) state_d = y_zero ? DONE : CALC;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    out_valid = (state_q == DONE);
    busy      = (state_q == CALC);
  end

  // STEPS restoring iterations chained within one clock
  always_comb begin
    acc_n  = acc_q;
    qsh_n  = qsh_q;
    acc_sh = '0;
    for (int s = 0; s < STEPS; s++) begin
      acc_sh = {acc_n[WIDTH-1:0], qsh_n[ITER-1]};
      qsh_n  = {qsh_n[ITER-2:0], 1'b0};
      if (acc_sh >= {1'b0, ymag_q}) begin
        acc_n    = acc_sh - {1'b0, ymag_q};
        qsh_n[0] = 1'b1;
      end else begin
        acc_n = acc_sh;
      end
    end
  end

  always_comb begin
    if (sgn_q) ovf_d = (xneg_q == yneg_q) ? (qsh_n >= HALF) : (qsh_n > HALF);
    else       ovf_d = ((qsh_n >> WIDTH) != '0);
    quo_d = (xneg_q ^ yneg_q) ? -qsh_n[WIDTH-1:0] : qsh_n[WIDTH-1:0];
    rem_d = xneg_q ? -acc_n[WIDTH-1:0] : acc_n[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sgn_q     <= 1'b0;
      xneg_q    <= 1'b0;
      yneg_q    <= 1'b0;
      ymag_q    <= '0;
      acc_q     <= '0;
      qsh_q     <= '0;
      cnt_q     <= '0;
      quo_res_q <= '0;
      rem_res_q <= '0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (accept) begin
      sgn_q     <= sgn;
      xneg_q    <= xneg_in;
      yneg_q    <= yneg_in;
      ymag_q    <= ymag_in;
      acc_q     <= '0;
      qsh_q     <= ITER'(xmag_in) << FBITS;
      cnt_q     <= '0;
      quo_res_q <= '0;
      rem_res_q <= '0;
      dbz_q     <= y_zero;
      ovf_q     <= 1'b0;
    end else if (state_q == CALC) begin
      acc_q <= acc_n;
      qsh_q <= qsh_n;
      cnt_q <= cnt_q + CW'(1);
      if (last_step) begin
        ovf_q     <= ovf_d;
        quo_res_q <= ovf_d ? '0 : quo_d;
        rem_res_q <= ovf_d ? '0 : rem_d;
      end
    end
  end

  assign q   = quo_res_q;
  assign r   = rem_res_q;
  assign dbz = dbz_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_div_pipe_hs.sv
// tb/tb_div_pipe_hs.sv - bench for div_pipe_hs over three parameter sets
// Instances share inputs; each is compared to an arithmetic reference model.
module tb_div_pipe_hs;

  localparam int FB [3] = '{0, 0, 4};
  localparam int NC [3] = '{8, 2, 6};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic sgn = 1'b0;
  logic out_ready = 1'b0;
  logic [7:0] x = '0, y = '0;
  logic [2:0] ir, ov, dz, of, bz;
  logic [2:0][7:0] qo, ro;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_pipe_hs #(.WIDTH(8), .FBITS(0), .STEPS(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .sgn(sgn), .x(x), .y(y),
    .out_valid(ov[0]), .out_ready(out_ready), .q(qo[0]), .r(ro[0]), .dbz(dz[0]),
    .ovf(of[0]), .busy(bz[0]));

  div_pipe_hs #(.WIDTH(8), .FBITS(0), .STEPS(4)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .sgn(sgn), .x(x), .y(y),
    .out_valid(ov[1]), .out_ready(out_ready), .q(qo[1]), .r(ro[1]), .dbz(dz[1]),
    .ovf(of[1]), .busy(bz[1]));

  div_pipe_hs #(.WIDTH(8), .FBITS(4), .STEPS(2)) u_f4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .sgn(sgn), .x(x), .y(y),
    .out_valid(ov[2]), .out_ready(out_ready), .q(qo[2]), .r(ro[2]), .dbz(dz[2]),
    .ovf(of[2]), .busy(bz[2]));

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  task automatic model(input int f, input bit sg, input logic [7:0] xv, input logic [7:0] yv,
                       output logic [7:0] eq, output logic [7:0] er, output bit ed, output bit eo);
    longint ax, ay, qm, rm;
    bit xn, yn;
    xn = sg & xv[7];
    yn = sg & yv[7];
    ax = xn ? 256 - longint'(xv) : longint'(xv);
    ay = yn ? 256 - longint'(yv) : longint'(yv);
    eq = '0; er = '0; ed = 1'b0; eo = 1'b0;
    if (yv == 0) begin
      ed = 1'b1;
    end else begin
      qm = (ax << f) / ay;
      rm = (ax << f) % ay;
      if (!sg)          eo = (qm >= 256);
      else if (xn == yn) eo = (qm >= 128);
      else              eo = (qm > 128);
      if (!eo) begin
        eq = (xn != yn) ? 8'(-qm) : 8'(qm);
        er = xn ? 8'(-rm) : 8'(rm);
      end
    end
  endtask

  task automatic collect(input bit sg, input logic [7:0] xv, input logic [7:0] yv);
    int lat [3];
    bit bseen [3];
    logic [7:0] eq, er;
    bit ed, eo;
    for (int i = 0; i < 3; i++) begin lat[i] = -1; bseen[i] = 1'b0; end
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      x = 8'($urandom); y = 8'($urandom); sgn = 1'($urandom);
      for (int i = 0; i < 3; i++) begin
        if (bz[i]) bseen[i] = 1'b1;
        if (ov[i] && lat[i] < 0) lat[i] = k;
      end
      if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
    end
    for (int i = 0; i < 3; i++) begin
      model(FB[i], sg, xv, yv, eq, er, ed, eo);
      chk("latency", i, lat[i], ed ? 0 : NC[i]);
      chk("busy_seen", i, 32'(bseen[i]), 32'(!ed));
      chk("q", i, 32'(qo[i]), 32'(eq));
      chk("r", i, 32'(ro[i]), 32'(er));
      chk("dbz", i, 32'(dz[i]), 32'(ed));
      chk("ovf", i, 32'(of[i]), 32'(eo));
    end
  endtask

  task automatic issue(input bit sg, input logic [7:0] xv, input logic [7:0] yv, input bit with_ready);
    in_valid = 1'b1; sgn = sg; x = xv; y = yv; out_ready = with_ready;
    #1;
    for (int i = 0; i < 3; i++) chk("in_ready_at_issue", i, 32'(ir[i]), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    collect(sg, xv, yv);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) chk("out_valid_after_release", i, 32'(ov[i]), 32'd0);
  endtask

  initial begin
    logic [7:0] hq [3];
    logic [7:0] hr [3];
    logic [2:0] stale;
    bit rs;
    logic [7:0] rx, ry;

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_out_valid", i, 32'(ov[i]), 32'd0);
      chk("reset_busy", i, 32'(bz[i]), 32'd0);
      chk("reset_q", i, 32'(qo[i]), 32'd0);
      chk("reset_r", i, 32'(ro[i]), 32'd0);
      chk("reset_flags", i, 32'({dz[i], of[i]}), 32'd0);
      chk("reset_in_ready", i, 32'(ir[i]), 32'd1);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    issue(1'b0, 8'd7, 8'd2, 1'b0);
    chk("q_7_div_2", 0, 32'(qo[0]), 32'd3);
    release_result();
    issue(1'b1, 8'hF9, 8'h02, 1'b0);
    chk("q_m7_div_2", 0, 32'(qo[0]), 32'hFD);
    chk("r_m7_div_2", 0, 32'(ro[0]), 32'hFF);
    release_result();
    issue(1'b1, 8'h80, 8'hFF, 1'b0);
    release_result();
    issue(1'b0, 8'h30, 8'h20, 1'b0);
    chk("q_fix_1p5", 2, 32'(qo[2]), 32'h18);
    release_result();
    issue(1'b0, 8'hF0, 8'h01, 1'b0);
    release_result();
    issue(1'b1, 8'h05, 8'h00, 1'b0);
    release_result();

    issue(1'b0, 8'd200, 8'd9, 1'b0);
    for (int i = 0; i < 3; i++) begin hq[i] = qo[i]; hr[i] = ro[i]; end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        chk("hold_q", i, 32'(qo[i]), 32'(hq[i]));
        chk("hold_r", i, 32'(ro[i]), 32'(hr[i]));
        chk("hold_valid", i, 32'(ov[i]), 32'd1);
        chk("hold_in_ready", i, 32'(ir[i]), 32'd0);
      end
    end
    issue(1'b0, 8'd100, 8'd7, 1'b1);
    chk("q_100_div_7", 0, 32'(qo[0]), 32'd14);
    chk("r_100_div_7", 0, 32'(ro[0]), 32'd2);
    release_result();

    for (int n = 0; n < 30; n++) begin
      rs = 1'($urandom);
      rx = 8'($urandom);
      ry = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      issue(rs, rx, ry, 1'b0);
      release_result();
    end

    in_valid = 1'b1; sgn = 1'b0; x = 8'd100; y = 8'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("busy_before_abort", 0, 32'(bz[0]), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("abort_out_valid", i, 32'(ov[i]), 32'd0);
      chk("abort_busy", i, 32'(bz[i]), 32'd0);
      chk("abort_q", i, 32'(qo[i]), 32'd0);
      chk("abort_r", i, 32'(ro[i]), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) chk("abort_in_ready", i, 32'(ir[i]), 32'd1);
    stale = '0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      stale = stale | ov;
    end
    for (int i = 0; i < 3; i++) chk("no_stale_result", i, 32'(stale[i]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
